// File: rtl/sdp_rd_arb.sv
// Two-requester round-robin read arbiter for the sdp read channel.
// An in-order tag FIFO routes each returning data beat back to its issuer.
module sdp_rd_arb #(
    parameter int W_ADDR    = 16,
    parameter int W_DATA    = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_addr_valid_i,
    input  logic [W_ADDR-1:0] req0_addr_data_i,
    output logic              req0_addr_ready_o,
    input  logic              req1_addr_valid_i,
    input  logic [W_ADDR-1:0] req1_addr_data_i,
    output logic              req1_addr_ready_o,
    output logic              req0_data_valid_o,
    output logic [W_DATA-1:0] req0_data_data_o,
    input  logic              req0_data_ready_i,
    output logic              req1_data_valid_o,
    output logic [W_DATA-1:0] req1_data_data_o,
    input  logic              req1_data_ready_i,
    output logic              mem_addr_valid_o,
    output logic [W_ADDR-1:0] mem_addr_data_o,
    input  logic              mem_addr_ready_i,
    input  logic              mem_data_valid_i,
    input  logic [W_DATA-1:0] mem_data_data_i,
    output logic              mem_data_ready_o,
    output logic              err_o
);

    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_OUTST);

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wptr_q, rptr_q;
    logic          tags_q [MAX_OUTST];
    logic          prio_q, lock_q, lock_sel_q, err_q;

    logic sel, can_issue, addr_vld, addr_hs;
    logic nonempty, head, data_rdy, data_hs;

    // A stalled grant stays locked so the address presented to memory holds.
    always_comb begin
        sel = 1'b0;
        if (lock_q)
            sel = lock_sel_q;
        else if (req0_addr_valid_i && req1_addr_valid_i)
            sel = prio_q;
        else
            sel = req1_addr_valid_i;
    end

    assign can_issue = count_q < FULL;
    assign addr_vld  = !rst && can_issue &&
                       (req0_addr_valid_i || req1_addr_valid_i);
    assign addr_hs   = addr_vld && mem_addr_ready_i;

    assign mem_addr_valid_o  = addr_vld;
    assign mem_addr_data_o   = sel ? req1_addr_data_i : req0_addr_data_i;
    assign req0_addr_ready_o = !rst && mem_addr_ready_i && can_issue && !sel;
    assign req1_addr_ready_o = !rst && mem_addr_ready_i && can_issue && sel;

    assign nonempty = count_q != '0;
    assign head     = tags_q[rptr_q];

    assign req0_data_valid_o = !rst && mem_data_valid_i && nonempty && !head;
    assign req1_data_valid_o = !rst && mem_data_valid_i && nonempty && head;
    assign req0_data_data_o  = mem_data_data_i;
    assign req1_data_data_o  = mem_data_data_i;

    // With nothing outstanding the beat is orphaned: accept and drop it.
    assign data_rdy = nonempty ?
                      (head ? req1_data_ready_i : req0_data_ready_i) : 1'b1;
    assign mem_data_ready_o = !rst && data_rdy;
    assign data_hs = mem_data_valid_i && mem_data_ready_o && nonempty;

    always_comb begin
        count_d = count_q;
        unique case ({addr_hs, data_hs})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            prio_q     <= 1'b0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            count_q <= count_d;
            if (addr_hs) begin
                wptr_q <= wptr_q + 1'b1;
                prio_q <= !sel;
                lock_q <= 1'b0;
            end else if (addr_vld) begin
                lock_q     <= 1'b1;
                lock_sel_q <= sel;
            end
            if (data_hs)
                rptr_q <= rptr_q + 1'b1;
            if (mem_data_valid_i && !nonempty)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (addr_hs)
            tags_q[wptr_q] <= sel;
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_sdp_rd_arb.sv
// Directed bench for sdp_rd_arb: arbitration, routing, full, lock, error.
// Inputs change 1ns after posedge; outputs are checked 1ns later.
module tb_sdp_rd_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0v, r1v, mar, mdv, r0dr, r1dr;
    logic [15:0] r0a, r1a, mdd;
    logic        r0ar, r1ar, r0dv, r1dv, mav, mdr, err;
    logic [15:0] r0dd, r1dd, mad;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sdp_rd_arb #(.W_ADDR(16), .W_DATA(16), .MAX_OUTST(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .req0_addr_valid_i (r0v),
        .req0_addr_data_i  (r0a),
        .req0_addr_ready_o (r0ar),
        .req1_addr_valid_i (r1v),
        .req1_addr_data_i  (r1a),
        .req1_addr_ready_o (r1ar),
        .req0_data_valid_o (r0dv),
        .req0_data_data_o  (r0dd),
        .req0_data_ready_i (r0dr),
        .req1_data_valid_o (r1dv),
        .req1_data_data_o  (r1dd),
        .req1_data_ready_i (r1dr),
        .mem_addr_valid_o  (mav),
        .mem_addr_data_o   (mad),
        .mem_addr_ready_i  (mar),
        .mem_data_valid_i  (mdv),
        .mem_data_data_i   (mdd),
        .mem_data_ready_o  (mdr),
        .err_o             (err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {r0v, r1v, mar, mdv, r0dr, r1dr} = '0;
        r0a = '0; r1a = '0; mdd = '0;
        cyc();
        // outputs held quiet while rst is high
        r0v = 1'b1; mar = 1'b1; mdv = 1'b1;
        settle();
        check("rst_mav", mav, 0);
        check("rst_r0ar", r0ar, 0);
        check("rst_mdr", mdr, 0);
        check("rst_err", err, 0);
        r0v = 1'b0; mdv = 1'b0;
        cyc();
        rst = 1'b0;
        settle();
        check("idle_mav", mav, 0);

        // single requester, three back-to-back reads
        r0v = 1'b1; r0a = 16'd3;
        settle();
        check("s_mav", mav, 1);
        check("s_a3", mad, 3);
        check("s_r0ar", r0ar, 1);
        check("s_r1ar", r1ar, 0);
        cyc(); r0a = 16'd7; settle();
        check("s_a7", mad, 7);
        cyc(); r0a = 16'd9; settle();
        check("s_a9", mad, 9);
        cyc(); r0v = 1'b0;
        r0dr = 1'b1; mdv = 1'b1; mdd = 16'h00A3;
        settle();
        check("s_d0v", r0dv, 1);
        check("s_d0", r0dd, 16'h00A3);
        check("s_d1v", r1dv, 0);
        check("s_mdr", mdr, 1);
        cyc(); mdd = 16'h00B7; settle();
        check("s_d1", r0dd, 16'h00B7);
        check("s_d1v_b", r1dv, 0);
        cyc(); mdd = 16'h00C9; settle();
        check("s_d2v", r0dv, 1);
        check("s_d2", r0dd, 16'h00C9);
        cyc(); mdv = 1'b0; settle();
        check("s_err", err, 0);

        // round-robin from reset, filling the tag FIFO
        do_reset();
        r0v = 1'b1; r1v = 1'b1; r0a = 16'h10; r1a = 16'h20; r0dr = 1'b0;
        settle();
        check("rr_0", mad, 16'h10);
        check("rr_0_r0ar", r0ar, 1);
        check("rr_0_r1ar", r1ar, 0);
        cyc(); r0a = 16'h11; settle();
        check("rr_1", mad, 16'h20);
        check("rr_1_r1ar", r1ar, 1);
        cyc(); r1a = 16'h21; settle();
        check("rr_2", mad, 16'h11);
        cyc(); r0a = 16'h12; settle();
        check("rr_3", mad, 16'h21);
        cyc(); r1a = 16'h22; settle();
        check("full_mav", mav, 0);
        check("full_r0ar", r0ar, 0);
        check("full_r1ar", r1ar, 0);
        // pop one; no same-cycle bypass into the full FIFO
        mdv = 1'b1; mdd = 16'h50; r0dr = 1'b1; r1dr = 1'b0;
        settle();
        check("pop_r0dv", r0dv, 1);
        check("pop_r1dv", r1dv, 0);
        check("pop_mav", mav, 0);
        cyc(); mdd = 16'h51; settle();
        check("regrant_mav", mav, 1);
        check("regrant_a", mad, 16'h12);
        check("bp_mdr", mdr, 0);
        check("bp_r1dv", r1dv, 1);
        cyc(); r0v = 1'b0; r1v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("bp_hold_mdr", mdr, 0);
            check("bp_hold_r0dv", r0dv, 0);
            cyc();
        end
        r1dr = 1'b1; settle();
        check("rel_mdr", mdr, 1);
        check("rel_r1", r1dd, 16'h51);
        cyc(); mdd = 16'h52; settle();
        check("ord_r0dv", r0dv, 1);
        check("ord_r1dv", r1dv, 0);
        cyc(); mdd = 16'h53; settle();
        check("ord_r1dv2", r1dv, 1);
        cyc(); mdd = 16'h54; settle();
        check("ord_r0dv2", r0dv, 1);
        cyc(); mdv = 1'b0; settle();
        check("drain_err", err, 0);

        // lock holds req1 while req0 rises mid-stall
        do_reset();
        r1v = 1'b1; r1a = 16'h30; mar = 1'b0;
        settle();
        check("lk_mav", mav, 1);
        check("lk_a0", mad, 16'h30);
        cyc(); r0v = 1'b1; r0a = 16'h40; settle();
        check("lk_a1", mad, 16'h30);
        check("lk_r0ar", r0ar, 0);
        cyc(); settle();
        check("lk_a2", mad, 16'h30);
        cyc(); mar = 1'b1; settle();
        check("lk_a3", mad, 16'h30);
        check("lk_r1ar", r1ar, 1);
        check("lk_r0ar2", r0ar, 0);
        cyc(); r1v = 1'b0; settle();
        check("lk_next", mad, 16'h40);
        check("lk_next_r0ar", r0ar, 1);
        cyc(); r0v = 1'b0;

        // reset with two reads outstanding, then orphan beat
        do_reset();
        settle();
        check("rs_err", err, 0);
        r0v = 1'b1; r1v = 1'b1; r0a = 16'h61; r1a = 16'h71; mar = 1'b0;
        settle();
        check("rs_prio", mad, 16'h61);
        r0v = 1'b0; r1v = 1'b0;
        r0dr = 1'b0; r1dr = 1'b0; mdv = 1'b1; mdd = 16'hEE;
        settle();
        check("orph_mdr", mdr, 1);
        check("orph_r0dv", r0dv, 0);
        check("orph_r1dv", r1dv, 0);
        check("orph_err0", err, 0);
        cyc(); mdv = 1'b0; settle();
        check("orph_err1", err, 1);
        cyc(); settle();
        check("orph_sticky", err, 1);
        do_reset();
        settle();
        check("clr_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
